decoding_parser: RTL and testbench
==================================

# decoding_parser

Receive-side counterpart of the encoding parser. Consumes the serial `serial_d`/`strobe`/`dict_err` stream and rebuilds each code length. Each length is pushed into a small show-ahead FIFO with a valid/ready output handshake. Sits between the serial link and the downstream dictionary/decode logic.

## Interface
- `MAX_LEN`, 127: largest legal code length; must be ≤ 127 (7-bit length field).
- `FIFO_DEPTH`, 2: output FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `serial_d`  in  1  serial data bit; qualified by `strobe`.
- `strobe`  in  1  bit-valid qualifier.
- `dict_err`  in  1  encoder empty-dictionary indication, level.
- `len_out`  out  7  head-of-FIFO code length; 0 = empty-dictionary marker.
- `len_valid`  out  1  FIFO non-empty.
- `len_ready`  in  1  consumer accepts head entry when `len_valid & len_ready`.
- `frame_err`  out  1  one-cycle pulse: malformed or aborted frame.
- `fifo_drop`  out  1  one-cycle pulse: completed entry lost because the FIFO was full.
- `busy`  out  1  high while in RUN or DRAIN.

## Operation
- **Frame format:**
  - N cycles of `strobe=1, serial_d=1`, then one terminator cycle of `strobe=1, serial_d=0`.
  - Decoded length = N, with 1 ≤ N ≤ MAX_LEN.
  - Frames may be back-to-back: the cycle after a terminator may start the next frame.
- **States:** IDLE, RUN, DRAIN. 7-bit counter `cnt`.
- **IDLE:**
  - `strobe=1, d=1` → RUN, `cnt=1`.
  - `strobe=1, d=0` → stray terminator (zero length): `frame_err` pulse, stay IDLE.
  - `strobe=0` → stay IDLE.
- **RUN:**
  - `strobe=1, d=1`, `cnt<MAX_LEN` → `cnt+1`.
  - `strobe=1, d=1`, `cnt==MAX_LEN` → overflow: `frame_err` pulse, go to DRAIN.
  - `strobe=1, d=0` → push `cnt`, go to IDLE.
  - `strobe=0` → truncated frame: `frame_err` pulse, go to IDLE, nothing pushed.
- **DRAIN:**
  - Discard bits until a terminator (`strobe=1, d=0`) or `strobe=0`, then go to IDLE.
  - No further `frame_err` pulse from that frame.
- **dict_err:**
  - Rising edge (0→1) in any state pushes a 0 entry.
  - In RUN or DRAIN it also aborts the frame: `frame_err` pulse if in RUN, go to IDLE. A terminator in that same cycle is ignored.
  - Held-high `dict_err` pushes once. Bits with `dict_err=1` are ignored; the state machine stays IDLE.
- **FIFO:**
  - A push when full and not simultaneously popped is dropped, with a `fifo_drop` pulse.
  - Push and pop in the same cycle are both honoured in every occupancy, full included.
  - Pointers wrap modulo FIFO_DEPTH.
  - At most one push per cycle. A `dict_err` edge takes priority over a terminator, which cannot coincide anyway since the abort discards it.

## Timing
- **Reset:** all outputs are 0 during and after reset: `len_out=0`, `len_valid=0`, `frame_err=0`, `fifo_drop=0`, `busy=0`. State IDLE, FIFO empty, `cnt=0`, `dict_err` edge register = 0.
- Reset asserted mid-frame discards the partial frame and FIFO contents with no error pulse.
- **Push latency:** the terminator is sampled at edge k; `len_valid`/`len_out` are visible after edge k+1 when the FIFO was empty.
- **Error latency:** `frame_err` and `fifo_drop` are registered, high for exactly the cycle after the offending edge.
- **busy:** registered; it reflects the state after each edge.
- **Handshake:**
  - `len_out` is stable while `len_valid=1` and `len_ready=0`.
  - The head advances on the edge where both are high.
  - `len_valid` must not depend combinationally on `len_ready`.
- **Throughput:** one frame per N+1 strobed cycles, with no dead cycle between frames.

## Test plan
- **Single frame:** `strobe=1` for 5 cycles, `d=1,1,1,1,0`, with `len_ready=1` → `len_out=4`, `len_valid` for one cycle, one edge after the terminator; no errors.
- **Back-to-back frames, stalled consumer:** frames of length 3, 1, 7, FIFO_DEPTH=2, `len_ready=0`.
  - Required: entries 3 and 1 are held and `fifo_drop` pulses once on 7.
  - Then raise `len_ready`: pops 3 then 1.
- **Overflow:** MAX_LEN=127, send 130 ones then a terminator → one `frame_err` pulse after the 128th one, no push, `busy` low after the terminator.
- **Truncation:**
  - 3 ones then `strobe=0` → `frame_err` pulse, no push.
  - A stray terminator in IDLE → `frame_err` pulse.
- **dict_err:** raise `dict_err` mid-frame (after 2 ones) and hold it for 4 cycles → one `frame_err` pulse and a single pushed 0 entry.
- **Reset:** assert `rst` during a frame with 1 FIFO entry pending → `len_valid=0` the next cycle, no error pulses. A subsequent length-2 frame decodes as 2.

Source files
------------

// File: rtl/decoding_parser.sv
// Serial unary-length frame decoder feeding a show-ahead length FIFO.
// Rebuilds code lengths from strobe/serial_d runs and flags malformed frames.
module decoding_parser #(
  parameter int MAX_LEN    = 127,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_d,
  input  logic       strobe,
  input  logic       dict_err,
  output logic [6:0] len_out,
  output logic       len_valid,
  input  logic       len_ready,
  output logic       frame_err,
  output logic       fifo_drop,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [6:0] MAXL = 7'(MAX_LEN);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state, state_n;
  logic [6:0]    cnt, cnt_n;
  logic          dict_q, dict_rise;
  logic          push_n, push_q;
  logic [6:0]    pval_n, pval_q;
  logic          err_n;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en;

  assign dict_rise = dict_err & ~dict_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    push_n  = 1'b0;
    pval_n  = cnt;
    err_n   = 1'b0;
    if (dict_rise) begin
      // Dictionary abort wins over any bit seen in the same cycle
      push_n  = 1'b1;
      pval_n  = '0;
      err_n   = (state == RUN);
      state_n = IDLE;
      cnt_n   = '0;
    end else if (dict_err) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && serial_d) begin
            state_n = RUN;
            cnt_n   = 7'd1;
          end else if (strobe) begin
            err_n = 1'b1;
          end
        end
        RUN: begin
          unique case (1'b1)
            !strobe: begin
              err_n   = 1'b1;
              state_n = IDLE;
              cnt_n   = '0;
            end
            strobe && !serial_d: begin
              push_n  = 1'b1;
              pval_n  = cnt;
              state_n = IDLE;
              cnt_n   = '0;
            end
            strobe && serial_d && (cnt == MAXL): begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end
            default: cnt_n = cnt + 7'd1;
          endcase
        end
        DRAIN: begin
          if (!strobe || !serial_d) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign len_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = len_valid & len_ready;
  // A full FIFO still accepts a push when the head leaves this cycle
  assign wr_en     = push_q & (~full | pop);
  assign len_out   = len_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pval_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dict_q    <= 1'b0;
      push_q    <= 1'b0;
      pval_q    <= '0;
      frame_err <= 1'b0;
      fifo_drop <= 1'b0;
      busy      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dict_q    <= dict_err;
      push_q    <= push_n;
      pval_q    <= pval_n;
      frame_err <= err_n;
      fifo_drop <= push_q & full & ~pop;
      busy      <= (state_n != IDLE);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decoding_parser.sv
// Directed bench for decoding_parser with a queue scoreboard on popped lengths.
// Error pulses are tallied by a monitor and checked as deltas per scenario.
module tb_decoding_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_d;
  logic       strobe;
  logic       dict_err;
  logic [6:0] len_out;
  logic       len_valid;
  logic       len_ready;
  logic       frame_err;
  logic       fifo_drop;
  logic       busy;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int drop_cnt = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_e;
  logic       mon_have;

  decoding_parser #(.MAX_LEN(127), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .serial_d(serial_d), .strobe(strobe),
    .dict_err(dict_err), .len_out(len_out), .len_valid(len_valid),
    .len_ready(len_ready), .frame_err(frame_err),
    .fifo_drop(fifo_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse tally plus scoreboard pop on every accepted handshake
  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (fifo_drop === 1'b1) drop_cnt++;
    if (!rst && len_valid === 1'b1 && len_ready === 1'b1) begin
      mon_have = (exp_q.size() > 0);
      mon_e = 7'h7f;
      if (mon_have) mon_e = exp_q.pop_front();
      total++;
      assert (mon_have && len_out === mon_e) else begin
        bad++;
        $error("FAIL pop: observed %0d expected %0d queued=%0b",
               len_out, mon_e, mon_have);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic s, input logic d);
    strobe = s;
    serial_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  int f0, d0;

  initial begin
    rst = 1'b1; serial_d = 1'b0; strobe = 1'b0;
    dict_err = 1'b0; len_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_len_out", len_out, 0);
    check("rst_len_valid", len_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_fifo_drop", fifo_drop, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(1);
    check("post_rst_valid", len_valid, 0);
    ferr_cnt = 0;
    drop_cnt = 0;

    // single frame of length 4
    len_ready = 1'b1;
    exp_q.push_back(7'd4);
    repeat (4) send(1'b1, 1'b1);
    check("single_busy_run", busy, 1);
    send(1'b1, 1'b0);
    check("single_busy_after_term", busy, 0);
    check("single_valid_k", len_valid, 0);
    idle(1);
    check("single_valid_k1", len_valid, 1);
    check("single_len", len_out, 4);
    idle(1);
    check("single_valid_gone", len_valid, 0);
    idle(1);
    check("single_no_err", ferr_cnt, 0);

    // back-to-back 3,1,7 with stalled consumer
    len_ready = 1'b0;
    d0 = drop_cnt;
    exp_q.push_back(7'd3);
    exp_q.push_back(7'd1);
    repeat (3) send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    repeat (7) send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    idle(3);
    check("b2b_drop_once", drop_cnt - d0, 1);
    check("b2b_valid", len_valid, 1);
    check("b2b_head", len_out, 3);
    idle(1);
    check("b2b_head_stable", len_out, 3);
    len_ready = 1'b1;
    idle(3);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_empty", len_valid, 0);
    check("b2b_no_err", ferr_cnt, 0);

    // overflow: 130 ones then terminator
    f0 = ferr_cnt;
    for (int i = 1; i <= 130; i++) begin
      send(1'b1, 1'b1);
      if (i == 127) check("ovf_no_pulse_127", frame_err, 0);
      if (i == 128) check("ovf_pulse_128", frame_err, 1);
      if (i == 129) check("ovf_drain_busy", busy, 1);
    end
    send(1'b1, 1'b0);
    check("ovf_busy_low", busy, 0);
    idle(3);
    check("ovf_one_pulse", ferr_cnt - f0, 1);
    check("ovf_no_push", len_valid, 0);

    // truncation and stray terminator
    f0 = ferr_cnt;
    repeat (3) send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    check("trunc_pulse", frame_err, 1);
    check("trunc_idle", busy, 0);
    send(1'b1, 1'b0);
    check("stray_pulse", frame_err, 1);
    idle(3);
    check("trunc_stray_cnt", ferr_cnt - f0, 2);
    check("trunc_no_push", len_valid, 0);

    // dict_err mid-frame, held 4 cycles
    f0 = ferr_cnt;
    exp_q.push_back(7'd0);
    repeat (2) send(1'b1, 1'b1);
    dict_err = 1'b1;
    send(1'b1, 1'b1);
    check("dict_abort_pulse", frame_err, 1);
    check("dict_abort_busy", busy, 0);
    send(1'b1, 1'b0);
    check("dict_held_no_pulse", frame_err, 0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    check("dict_held_idle", busy, 0);
    dict_err = 1'b0;
    idle(4);
    check("dict_one_pulse", ferr_cnt - f0, 1);
    check("dict_single_push", exp_q.size(), 0);
    check("dict_empty", len_valid, 0);

    // reset mid-frame with an entry pending
    len_ready = 1'b0;
    f0 = ferr_cnt;
    d0 = drop_cnt;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    check("rstmid_pending", len_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    send(1'b1, 1'b1);
    check("rstmid_valid", len_valid, 0);
    check("rstmid_ferr", frame_err, 0);
    check("rstmid_drop", fifo_drop, 0);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    idle(1);
    exp_q.push_back(7'd2);
    len_ready = 1'b1;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    idle(3);
    check("rstmid_len2_popped", exp_q.size(), 0);
    check("rstmid_no_err", ferr_cnt - f0, 0);
    check("rstmid_no_drop", drop_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
